// File: rtl/sweep_if.sv
// rtl/sweep_if.sv - host and counter-side signals of the sweep sequencer
// master = host/counter environment, slave = sweep_ctrl.
interface sweep_if #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 4
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   hi;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         cycles;
  logic [WIDTH-1:0]   cnt_val;
  logic               cnt_load;
  logic [WIDTH-1:0]   cnt_load_val;
  logic               cnt_en;
  logic               cnt_up;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, abort, lo, hi, dwell, cycles, cnt_val,
    input  cnt_load, cnt_load_val, cnt_en, cnt_up, busy, done, err
  );

  modport slave (
    input  start, abort, lo, hi, dwell, cycles, cnt_val,
    output cnt_load, cnt_load_val, cnt_en, cnt_up, busy, done, err
  );
endinterface

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - sequences an external up/down counter through lo->hi->lo sweeps
// with a dwell at each limit, for a programmed number of round trips.
module sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 4
) (
  input  logic   clk,
  input  logic   rst,
  sweep_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RISE, DWELL_HI, FALL, DWELL_LO, DONE
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] timer_q;
  logic [3:0]         cycles_q;
  logic [3:0]         trips_q;
  logic [3:0]         trips_next;
  logic               dir_q;
  logic               err_q;
  logic               at_hi;
  logic               at_lo;

  assign at_hi      = (bus.cnt_val == hi_q);
  assign at_lo      = (bus.cnt_val == lo_q);
  assign trips_next = trips_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      dwell_q  <= '0;
      timer_q  <= '0;
      cycles_q <= '0;
      trips_q  <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == RISE)
        dir_q <= 1'b1;
      else if (state_q == FALL)
        dir_q <= 1'b0;

      if (bus.abort && state_q != IDLE) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            // abort in IDLE swallows a simultaneous start, including its err
            if (bus.start && !bus.abort) begin
              if (bus.lo < bus.hi) begin
                lo_q     <= bus.lo;
                hi_q     <= bus.hi;
                dwell_q  <= bus.dwell;
                cycles_q <= bus.cycles;
                trips_q  <= '0;
                timer_q  <= '0;
                state_q  <= LOAD;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          LOAD: state_q <= RISE;
          RISE: if (at_hi) state_q <= DWELL_HI;
          DWELL_HI: begin
            if (timer_q == dwell_q) begin
              timer_q <= '0;
              state_q <= FALL;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          FALL: if (at_lo) state_q <= DWELL_LO;
          DWELL_LO: begin
            if (timer_q == dwell_q) begin
              timer_q <= '0;
              trips_q <= trips_next;
              if (cycles_q != 4'd0 && trips_next == cycles_q)
                state_q <= DONE;
              else
                state_q <= RISE;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Steps are gated on the live counter value so the counter halts exactly on a limit.
  assign bus.cnt_en       = !bus.abort &&
                            ((state_q == RISE && !at_hi) || (state_q == FALL && !at_lo));
  assign bus.cnt_up       = (state_q == RISE) ? 1'b1 : (state_q == FALL) ? 1'b0 : dir_q;
  assign bus.cnt_load     = (state_q == LOAD) && !bus.abort;
  assign bus.cnt_load_val = lo_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.err          = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - directed self-checking bench for sweep_ctrl with a behavioural counter
module tb_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  sweep_if #(.WIDTH(4), .DWELL_W(4)) bus ();

  sweep_ctrl #(.WIDTH(4), .DWELL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= 4'd0;
    else if (bus.cnt_load)
      cnt <= bus.cnt_load_val;
    else if (bus.cnt_en)
      cnt <= bus.cnt_up ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign bus.cnt_val = cnt;

  int done_at, ndone, ups, downs, loads, viol;
  int trace [0:127];
  int busy_tr [0:127];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep and records what happens over maxc cycles (cycle 1 = LOAD).
  // At cycle inj_at a second start with different limits is pulsed.
  task automatic run(input int l, input int h, input int dw, input int cy,
                     input int maxc, input int inj_at);
    done_at = 0; ndone = 0; ups = 0; downs = 0; loads = 0; viol = 0;
    bus.lo = 4'(l); bus.hi = 4'(h); bus.dwell = 4'(dw); bus.cycles = 4'(cy);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      trace[k]   = int'(cnt);
      busy_tr[k] = int'(bus.busy);
      if (bus.cnt_load) loads++;
      if (bus.cnt_en && bus.cnt_up) ups++;
      if (bus.cnt_en && !bus.cnt_up) downs++;
      if (bus.cnt_en && bus.cnt_up && int'(cnt) >= h) viol++;
      if (bus.cnt_en && !bus.cnt_up && int'(cnt) <= l) viol++;
      if (bus.done) begin
        ndone++;
        if (done_at == 0) done_at = k;
      end
      if (k == inj_at) begin
        bus.start = 1'b1; bus.lo = 4'd0; bus.hi = 4'd9;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    bit aborted;
    int nf;
    int frozen;
    int late_done;

    bus.start = 1'b0; bus.abort = 1'b0;
    bus.lo = '0; bus.hi = '0; bus.dwell = '0; bus.cycles = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_load", bus.cnt_load, 0);
    check("rst_en", bus.cnt_en, 0);
    check("rst_up", bus.cnt_up, 0);
    check("rst_loadval", bus.cnt_load_val, 0);
    rst = 1'b0;
    tick();

    // basic sweep
    run(2, 5, 2, 1, 20, 0);
    check("t1_done_at", done_at, 16);
    check("t1_ndone", ndone, 1);
    check("t1_ups", ups, 3);
    check("t1_downs", downs, 3);
    check("t1_loads", loads, 1);
    check("t1_viol", viol, 0);
    check("t1_cnt2", trace[2], 2);
    check("t1_cnt5", trace[5], 5);
    check("t1_cnt8", trace[8], 5);
    check("t1_cnt10", trace[10], 4);
    check("t1_cnt12", trace[12], 2);
    check("t1_cnt16", trace[16], 2);
    check("t1_busy1", busy_tr[1], 1);
    check("t1_busy17", busy_tr[17], 0);

    // rejected start
    bus.lo = 4'd5; bus.hi = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t2_err", bus.err, 1);
    check("t2_busy", bus.busy, 0);
    check("t2_load", bus.cnt_load, 0);
    tick();
    check("t2_err_pulse", bus.err, 0);
    check("t2_busy2", bus.busy, 0);

    // full-range, two trips
    run(0, 15, 0, 2, 75, 0);
    check("t3_done_at", done_at, 70);
    check("t3_ndone", ndone, 1);
    check("t3_ups", ups, 30);
    check("t3_downs", downs, 30);
    check("t3_viol", viol, 0);
    check("t3_busy", busy_tr[75], 0);

    // continuous, abort during 3rd FALL
    bus.lo = 4'd1; bus.hi = 4'd3; bus.dwell = 4'd1; bus.cycles = 4'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    aborted = 0; nf = 0; late_done = 0; frozen = 0;
    for (int k = 0; k < 200 && !aborted; k++) begin
      if (bus.done) late_done++;
      if (bus.cnt_en && !bus.cnt_up && cnt == 4'd3) nf++;
      if (nf == 3) begin
        bus.abort = 1'b1;
        #1;
        check("t4_en_abort", bus.cnt_en, 0);
        frozen = int'(cnt);
        tick();
        bus.abort = 1'b0;
        check("t4_busy", bus.busy, 0);
        aborted = 1;
      end else begin
        tick();
      end
    end
    check("t4_aborted", aborted, 1);
    repeat (5) begin
      if (bus.done) late_done++;
      tick();
    end
    check("t4_frozen", cnt, frozen);
    check("t4_frozen_val", cnt, 3);
    check("t4_no_done", late_done, 0);

    // start while busy is ignored
    run(2, 5, 0, 1, 14, 3);
    check("t5_done_at", done_at, 12);
    check("t5_viol", viol, 0);
    check("t5_cnt6", trace[6], 5);
    check("t5_cnt11", trace[11], 2);
    check("t5_loads", loads, 1);

    // asynchronous reset mid-RISE
    bus.lo = 4'd0; bus.hi = 4'd10; bus.dwell = 4'd0; bus.cycles = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("t6_rising", bus.cnt_en, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", bus.busy, 0);
    check("t6_en", bus.cnt_en, 0);
    check("t6_up", bus.cnt_up, 0);
    check("t6_cnt", cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run(2, 5, 2, 1, 20, 0);
    check("t6_done_at", done_at, 16);
    check("t6_ndone", ndone, 1);
    check("t6_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
